// File: rtl/vis_frame_buffer.sv
// Double-buffered visibility frame store: captures complete accumulator frames
// into two banks and replays them in commit order as a backpressured AXI4-Stream.
module vis_frame_buffer #(
    parameter int WIDTH = 36,
    parameter int NSUMS = 1024,
    parameter int DBITS = 16
) (
    input  logic             clock_i,
    input  logic             reset_ni,
    input  logic             valid_i,
    input  logic             first_i,
    input  logic             last_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast,
    output logic             m_tuser,
    output logic [WIDTH-1:0] m_tdata,
    output logic             overflow_o,
    output logic [DBITS-1:0] dropped_o
);
    localparam int ABITS = $clog2(NSUMS);
    localparam logic [ABITS:0] LEN_MAX = (ABITS+1)'(NSUMS);
    localparam logic [ABITS:0] LEN_ONE = (ABITS+1)'(1);

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_st_t;
    typedef enum logic {IDLE, DRAIN} rd_st_t;
    typedef struct packed {
        logic             bank;
        logic             user;
        logic             last;
        logic [WIDTH-1:0] data;
    } beat_t;

    function automatic logic [DBITS-1:0] sat_inc(input logic [DBITS-1:0] v);
        return (&v) ? v : v + DBITS'(1);
    endfunction

    logic             rst_n;
    bank_st_t         bank_st  [2];
    logic [ABITS:0]   bank_len [2];
    logic [WIDTH-1:0] mem0 [NSUMS];
    logic [WIDTH-1:0] mem1 [NSUMS];

    logic             wsel, wopen;
    logic [ABITS:0]   wcnt;
    logic             fst, acc_first, drop, commit, wr_en;
    logic [ABITS-1:0] wr_addr;
    logic [ABITS:0]   commit_len;

    rd_st_t           rd_st, rd_st_nx;
    logic             rsel;
    logic [ABITS:0]   rcnt, rd_idx;
    logic             rd_en_p0, rd_last_p0, rd_user_p0;
    logic [ABITS-1:0] rd_addr_p0;
    logic             vld_p1, rd_bank_p1, rd_last_p1, rd_user_p1;
    logic [WIDTH-1:0] rd0_p1, rd1_p1;
    beat_t            beat_p1, q0, q1;
    logic [1:0]       fcnt;
    logic [2:0]       occ;
    logic             pop;

    // Release is re-timed to the clock; assertion stays asynchronous.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) rst_n <= 1'b0;
        else           rst_n <= 1'b1;
    end

    always_comb begin
        fst        = valid_i & first_i;
        acc_first  = fst & (wopen | (bank_st[wsel] == EMPTY));
        drop       = fst & (wopen | (bank_st[wsel] != EMPTY));
        wr_en      = acc_first | (valid_i & ~first_i & wopen & (wcnt != LEN_MAX));
        wr_addr    = first_i ? '0 : wcnt[ABITS-1:0];
        commit     = valid_i & last_i & (first_i ? acc_first : wopen);
        commit_len = first_i ? LEN_ONE : ((wcnt == LEN_MAX) ? LEN_MAX : wcnt + LEN_ONE);
    end

    always_comb begin
        pop    = (fcnt != 2'd0) & m_tready;
        occ    = {1'b0, fcnt} + {2'b0, vld_p1} - {2'b0, pop};
        rd_idx = (rd_st == IDLE) ? '0 : rcnt;
    end

    always_ff @(posedge clock_i or negedge rst_n) begin
        if (!rst_n) rd_st <= IDLE;
        else        rd_st <= rd_st_nx;
    end

    always_comb begin
        rd_st_nx = rd_st;
        case (rd_st)
            IDLE:    if (rd_en_p0 && !rd_last_p0) rd_st_nx = DRAIN;
            DRAIN:   if (rd_en_p0 &&  rd_last_p0) rd_st_nx = IDLE;
            default: rd_st_nx = IDLE;
        endcase
    end

    // Issue only when the FIFO is sure to have room for next cycle's word.
    always_comb begin
        rd_en_p0   = (occ <= 3'd1) & ((rd_st == DRAIN) | (bank_st[rsel] == FULL));
        rd_addr_p0 = rd_idx[ABITS-1:0];
        rd_last_p0 = (rd_idx + LEN_ONE) == bank_len[rsel];
        rd_user_p0 = (rd_st == IDLE);
    end

    always_ff @(posedge clock_i or negedge rst_n) begin
        if (!rst_n) begin
            bank_st[0]  <= EMPTY;
            bank_st[1]  <= EMPTY;
            bank_len[0] <= '0;
            bank_len[1] <= '0;
            wsel        <= 1'b0;
            wopen       <= 1'b0;
            wcnt        <= '0;
            rsel        <= 1'b0;
            rcnt        <= '0;
            vld_p1      <= 1'b0;
            fcnt        <= 2'd0;
            overflow_o  <= 1'b0;
            dropped_o   <= '0;
        end else begin
            if (fst) begin
                wopen <= acc_first & ~last_i;
                if (acc_first) wcnt <= LEN_ONE;
            end else if (valid_i && wopen) begin
                if (wcnt != LEN_MAX) wcnt <= wcnt + LEN_ONE;
                if (last_i) wopen <= 1'b0;
            end
            if (acc_first && !last_i) bank_st[wsel] <= FILLING;
            if (commit) begin
                bank_st[wsel]  <= FULL;
                bank_len[wsel] <= commit_len;
                wsel           <= ~wsel;
            end
            if (drop) begin
                overflow_o <= 1'b1;
                dropped_o  <= sat_inc(dropped_o);
            end
            if (rd_en_p0) begin
                rcnt <= rd_idx + LEN_ONE;
                if (rd_st == IDLE) bank_st[rsel] <= DRAINING;
                if (rd_last_p0) rsel <= ~rsel;
            end
            // A bank is only released once its final word has left the FIFO.
            if (pop && q0.last) bank_st[q0.bank] <= EMPTY;
            vld_p1 <= rd_en_p0;
            fcnt   <= fcnt + {1'b0, vld_p1} - {1'b0, pop};
        end
    end

    always_ff @(posedge clock_i) begin
        if (wr_en && !wsel)    mem0[wr_addr] <= data_i;
        if (rd_en_p0 && !rsel) rd0_p1 <= mem0[rd_addr_p0];
    end

    always_ff @(posedge clock_i) begin
        if (wr_en && wsel)    mem1[wr_addr] <= data_i;
        if (rd_en_p0 && rsel) rd1_p1 <= mem1[rd_addr_p0];
    end

    // p0 -> p1: read port output
    always_ff @(posedge clock_i) begin
        if (rd_en_p0) begin
            rd_bank_p1 <= rsel;
            rd_last_p1 <= rd_last_p0;
            rd_user_p1 <= rd_user_p0;
        end
    end

    always_comb begin
        beat_p1.bank = rd_bank_p1;
        beat_p1.user = rd_user_p1;
        beat_p1.last = rd_last_p1;
        beat_p1.data = rd_bank_p1 ? rd1_p1 : rd0_p1;
    end

    // p1 -> output skid FIFO; q0 is the head and only moves on pop or when empty
    always_ff @(posedge clock_i) begin
        if ((fcnt == 2'd0 && vld_p1) || (fcnt == 2'd1 && pop && vld_p1)) q0 <= beat_p1;
        else if (fcnt == 2'd2 && pop)                                      q0 <= q1;
        if ((fcnt == 2'd1 && vld_p1 && !pop) || (fcnt == 2'd2 && pop && vld_p1)) q1 <= beat_p1;
    end

    always_comb begin
        m_tvalid = (fcnt != 2'd0);
        m_tdata  = m_tvalid ? q0.data : '0;
        m_tlast  = m_tvalid & q0.last;
        m_tuser  = m_tvalid & q0.user;
    end

endmodule

// File: tb/tb_vis_frame_buffer.sv
// Directed testbench for vis_frame_buffer with NSUMS=8: capture, replay,
// backpressure, overflow, clamping, abort and reset behaviour.
module tb_vis_frame_buffer;
    localparam int W = 16;
    localparam int N = 8;
    localparam int D = 16;

    logic         clock_i  = 1'b0;
    logic         reset_ni = 1'b0;
    logic         valid_i  = 1'b0;
    logic         first_i  = 1'b0;
    logic         last_i   = 1'b0;
    logic [W-1:0] data_i   = '0;
    logic         m_tready = 1'b0;
    logic         m_tvalid, m_tlast, m_tuser, overflow_o;
    logic [W-1:0] m_tdata;
    logic [D-1:0] dropped_o;

    typedef struct {
        logic         user;
        logic         last;
        logic [W-1:0] data;
        int           cyc;
    } beat_t;

    beat_t beats[$];
    beat_t mon_b;
    int    cyc    = 0;
    int    n_cmp  = 0;
    int    n_fail = 0;

    vis_frame_buffer #(.WIDTH(W), .NSUMS(N), .DBITS(D)) dut (
        .clock_i(clock_i), .reset_ni(reset_ni),
        .valid_i(valid_i), .first_i(first_i), .last_i(last_i), .data_i(data_i),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .m_tuser(m_tuser), .m_tdata(m_tdata),
        .overflow_o(overflow_o), .dropped_o(dropped_o)
    );

    always #5 clock_i = ~clock_i;
    always @(posedge clock_i) cyc <= cyc + 1;

    always @(negedge clock_i) begin
        if (m_tvalid && m_tready) begin
            mon_b.user = m_tuser;
            mon_b.last = m_tlast;
            mon_b.data = m_tdata;
            mon_b.cyc  = cyc;
            beats.push_back(mon_b);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic send_word(input logic f, input logic l, input logic [W-1:0] d);
        valid_i = 1'b1; first_i = f; last_i = l; data_i = d;
        tick();
    endtask

    task automatic idle();
        valid_i = 1'b0; first_i = 1'b0; last_i = 1'b0; data_i = '0;
    endtask

    task automatic do_reset();
        idle();
        reset_ni = 1'b0;
        tick(); tick();
        reset_ni = 1'b1;
        tick(); tick();
        beats.delete();
    endtask

    task automatic wait_beats(input int n, input int budget);
        for (int i = 0; i < budget && beats.size() < n; i++) tick();
    endtask

    task automatic test_reset();
        idle();
        m_tready = 1'b0;
        reset_ni = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({m_tvalid, m_tlast, m_tuser} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctl got v/l/u=%b%b%b want 000", m_tvalid, m_tlast, m_tuser);
        end
        n_cmp++;
        if (m_tdata !== '0) begin
            n_fail++; $display("FAIL reset_tdata got %0d want 0", m_tdata);
        end
        n_cmp++;
        if (overflow_o !== 1'b0 || dropped_o !== '0) begin
            n_fail++; $display("FAIL reset_cnt got ovf=%b drop=%0d want 0/0", overflow_o, dropped_o);
        end
        reset_ni = 1'b1;
        tick(); tick(); tick();
        n_cmp++;
        if (m_tvalid !== 1'b0) begin
            n_fail++; $display("FAIL reset_release_tvalid got %b want 0", m_tvalid);
        end
    endtask

    task automatic test_single_frame();
        int k;
        do_reset();
        m_tready = 1'b1;
        for (int i = 0; i < 8; i++) send_word(i == 0, i == 7, W'(i + 1));
        k = cyc;
        idle();
        wait_beats(8, 40);
        tick(); tick();
        n_cmp++;
        if (beats.size() != 8) begin
            n_fail++; $display("FAIL single_count got %0d want 8", beats.size());
        end
        for (int i = 0; i < beats.size() && i < 8; i++) begin
            n_cmp++;
            if (beats[i].data !== W'(i + 1) || beats[i].user !== (i == 0) ||
                beats[i].last !== (i == 7) || beats[i].cyc != k + 2 + i) begin
                n_fail++;
                $display("FAIL single_beat%0d got d=%0d u=%b l=%b cyc=%0d want d=%0d u=%b l=%b cyc=%0d",
                         i, beats[i].data, beats[i].user, beats[i].last, beats[i].cyc,
                         i + 1, i == 0, i == 7, k + 2 + i);
            end
        end
        n_cmp++;
        if (dropped_o !== '0 || overflow_o !== 1'b0) begin
            n_fail++; $display("FAIL single_drop got drop=%0d ovf=%b want 0/0", dropped_o, overflow_o);
        end
    endtask

    task automatic test_backpressure();
        int got;
        do_reset();
        m_tready = 1'b0;
        for (int i = 0; i < 8; i++) send_word(i == 0, i == 7, W'(11 + i));
        idle();
        got = 0;
        for (int i = 0; i < 120 && got < 8; i++) begin
            m_tready = (i % 4 == 0) || (i % 4 == 3);
            if (m_tvalid) begin
                n_cmp++;
                if (m_tdata !== W'(11 + got) || m_tuser !== (got == 0) || m_tlast !== (got == 7)) begin
                    n_fail++;
                    $display("FAIL bp_word%0d got d=%0d u=%b l=%b want d=%0d u=%b l=%b",
                             got, m_tdata, m_tuser, m_tlast, 11 + got, got == 0, got == 7);
                end
                if (m_tready) got++;
            end
            tick();
        end
        n_cmp++;
        if (got != 8) begin
            n_fail++; $display("FAIL bp_done got %0d words want 8", got);
        end
        m_tready = 1'b1;
        tick(); tick(); tick(); tick(); tick();
        n_cmp++;
        if (m_tvalid !== 1'b0 || beats.size() != 8) begin
            n_fail++; $display("FAIL bp_once got tvalid=%b beats=%0d want 0/8", m_tvalid, beats.size());
        end
    endtask

    task automatic test_overflow();
        do_reset();
        m_tready = 1'b0;
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < 8; i++) send_word(i == 0, i == 7, W'(21 + 10 * f + i));
        idle();
        tick(); tick();
        n_cmp++;
        if (overflow_o !== 1'b1 || dropped_o !== D'(1)) begin
            n_fail++; $display("FAIL ovf_flags got ovf=%b drop=%0d want 1/1", overflow_o, dropped_o);
        end
        n_cmp++;
        if (m_tvalid !== 1'b1 || m_tdata !== W'(21)) begin
            n_fail++; $display("FAIL ovf_hold got v=%b d=%0d want 1/21", m_tvalid, m_tdata);
        end
        m_tready = 1'b1;
        wait_beats(16, 60);
        for (int i = 0; i < 20; i++) tick();
        n_cmp++;
        if (beats.size() != 16) begin
            n_fail++; $display("FAIL ovf_count got %0d want 16", beats.size());
        end
        for (int i = 0; i < beats.size() && i < 16; i++) begin
            n_cmp++;
            if (beats[i].data !== W'((i < 8) ? 21 + i : 23 + i) ||
                beats[i].user !== (i == 0 || i == 8) || beats[i].last !== (i == 7 || i == 15) ||
                beats[i].cyc != beats[0].cyc + i) begin
                n_fail++;
                $display("FAIL ovf_beat%0d got d=%0d u=%b l=%b cyc=%0d want d=%0d u=%b l=%b cyc=%0d",
                         i, beats[i].data, beats[i].user, beats[i].last, beats[i].cyc,
                         (i < 8) ? 21 + i : 23 + i, i == 0 || i == 8, i == 7 || i == 15,
                         beats[0].cyc + i);
            end
        end
        n_cmp++;
        if (dropped_o !== D'(1)) begin
            n_fail++; $display("FAIL ovf_drop_final got %0d want 1", dropped_o);
        end
    endtask

    task automatic test_short_and_clamp();
        do_reset();
        m_tready = 1'b1;
        for (int i = 0; i < 3; i++)  send_word(i == 0, i == 2, W'(51 + i));
        for (int i = 0; i < 10; i++) send_word(i == 0, i == 9, W'(61 + i));
        idle();
        wait_beats(11, 60);
        for (int i = 0; i < 10; i++) tick();
        n_cmp++;
        if (beats.size() != 11) begin
            n_fail++; $display("FAIL short_count got %0d want 11", beats.size());
        end
        for (int i = 0; i < beats.size() && i < 11; i++) begin
            n_cmp++;
            if (beats[i].data !== W'((i < 3) ? 51 + i : 58 + i) ||
                beats[i].user !== (i == 0 || i == 3) || beats[i].last !== (i == 2 || i == 10)) begin
                n_fail++;
                $display("FAIL short_beat%0d got d=%0d u=%b l=%b want d=%0d u=%b l=%b",
                         i, beats[i].data, beats[i].user, beats[i].last,
                         (i < 3) ? 51 + i : 58 + i, i == 0 || i == 3, i == 2 || i == 10);
            end
        end
    endtask

    task automatic test_abort_and_single_word();
        do_reset();
        m_tready = 1'b1;
        for (int i = 0; i < 3; i++) send_word(i == 0, 1'b0, W'(71 + i));
        for (int i = 0; i < 4; i++) send_word(i == 0, i == 3, W'(81 + i));
        idle();
        tick();
        send_word(1'b1, 1'b1, W'(91));
        idle();
        wait_beats(5, 40);
        for (int i = 0; i < 10; i++) tick();
        n_cmp++;
        if (beats.size() != 5) begin
            n_fail++; $display("FAIL abort_count got %0d want 5", beats.size());
        end
        for (int i = 0; i < beats.size() && i < 5; i++) begin
            n_cmp++;
            if (beats[i].data !== W'((i < 4) ? 81 + i : 91) ||
                beats[i].user !== (i == 0 || i == 4) || beats[i].last !== (i == 3 || i == 4)) begin
                n_fail++;
                $display("FAIL abort_beat%0d got d=%0d u=%b l=%b want d=%0d u=%b l=%b",
                         i, beats[i].data, beats[i].user, beats[i].last,
                         (i < 4) ? 81 + i : 91, i == 0 || i == 4, i == 3 || i == 4);
            end
        end
        n_cmp++;
        if (dropped_o !== D'(1)) begin
            n_fail++; $display("FAIL abort_drop got %0d want 1", dropped_o);
        end
    endtask

    task automatic test_reset_mid_drain();
        bit seen;
        beats.delete();
        m_tready = 1'b1;
        for (int i = 0; i < 8; i++) send_word(i == 0, i == 7, W'(101 + i));
        idle();
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (m_tvalid && m_tdata == W'(103)) seen = 1'b1;
            else tick();
        end
        n_cmp++;
        if (!seen || beats.size() != 2) begin
            n_fail++; $display("FAIL rst_pre got seen=%b beats=%0d want 1/2", seen, beats.size());
        end
        reset_ni = 1'b0;
        #1;
        n_cmp++;
        if ({m_tvalid, m_tlast, m_tuser} !== 3'b000 || m_tdata !== '0) begin
            n_fail++; $display("FAIL rst_async got v/l/u=%b%b%b d=%0d want 000/0", m_tvalid, m_tlast, m_tuser, m_tdata);
        end
        n_cmp++;
        if (dropped_o !== '0) begin
            n_fail++; $display("FAIL rst_cnt got drop=%0d want 0", dropped_o);
        end
        tick(); tick();
        reset_ni = 1'b1;
        tick(); tick();
        beats.delete();
        for (int i = 0; i < 8; i++) send_word(i == 0, i == 7, W'(111 + i));
        idle();
        wait_beats(8, 40);
        for (int i = 0; i < 10; i++) tick();
        n_cmp++;
        if (beats.size() != 8) begin
            n_fail++; $display("FAIL rst_post_count got %0d want 8", beats.size());
        end
        for (int i = 0; i < beats.size() && i < 8; i++) begin
            n_cmp++;
            if (beats[i].data !== W'(111 + i) || beats[i].user !== (i == 0) || beats[i].last !== (i == 7)) begin
                n_fail++;
                $display("FAIL rst_post_beat%0d got d=%0d u=%b l=%b want d=%0d u=%b l=%b",
                         i, beats[i].data, beats[i].user, beats[i].last, 111 + i, i == 0, i == 7);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_overflow();
        test_short_and_clamp();
        test_abort_and_single_word();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
